// File: rtl/quad_encoder_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : quad_encoder_pkg
// Description : Shared types and constants for the quadrature encoder
//               transmitter: FSM state encoding, rest level of the A/B pins
//               and the clockwise / counter-clockwise Gray sequences.
// Revision    : 1.0 - initial release
// ============================================================================
package quad_encoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PHASE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Both contacts open: pulled-up rest level between detents.
    localparam logic [1:0] REST_AB = 2'b11;

    // Index 0 is the detent rest position; entries are {A,B}.
    // CW : 11 -> 01 -> 00 -> 10 (A leads)
    // CCW: 11 -> 10 -> 00 -> 01 (B leads)
    localparam logic [3:0][1:0] C_CW_GRAY  = {2'b10, 2'b00, 2'b01, REST_AB};
    localparam logic [3:0][1:0] C_CCW_GRAY = {2'b01, 2'b00, 2'b10, REST_AB};

    function automatic logic [1:0] gray_ab(input logic dir, input logic [1:0] idx);
        return dir ? C_CW_GRAY[idx] : C_CCW_GRAY[idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/quad_encoder_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : quad_encoder_tx_if
// Description : Command handshake between a stimulus source (master) and the
//               quadrature encoder transmitter (slave).
//               cmd_valid/cmd_ready : valid/ready handshake
//               cmd_dir             : 1 = CW, 0 = CCW
//               cmd_steps           : number of detents to emit (0 is legal)
// Revision    : 1.0 - initial release
// ============================================================================
interface quad_encoder_tx_if #(
    parameter int STEPS_W = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_dir;
    logic [STEPS_W-1:0] cmd_steps;

    modport master (output cmd_valid, output cmd_dir, output cmd_steps, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_dir, input  cmd_steps, output cmd_ready);

endinterface
`default_nettype wire

// File: rtl/quad_encoder_tx_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : quad_phase_timer
// Description : Prescaler that emits a one-cycle tick every PHASE_CYCLES
//               enabled cycles. A clear restarts the count at zero so the
//               first tick lands exactly PHASE_CYCLES cycles later.
//   clk     : clock
//   rst     : synchronous active-high reset
//   i_clear : restart the count
//   i_en    : count enable
//   o_tick  : one-cycle pulse on the last count of each period
// Revision    : 1.0 - initial release
// ============================================================================
module quad_phase_timer #(
    parameter int PHASE_CYCLES = 1000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    input  wire logic i_en,
    output logic      o_tick
);

    localparam int                 C_CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(PHASE_CYCLES - 1);

    logic [C_CNT_W-1:0] r_cnt;
    logic               w_wrap;

    assign w_wrap = (r_cnt == C_LAST);
    assign o_tick = i_en && w_wrap;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + C_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/quad_encoder_tx.sv
`default_nettype none
// ============================================================================
// Module      : quad_encoder_tx
// Description : Quadrature encoder transmitter. Turns detent commands into
//               Gray-coded A/B waveforms and keeps a signed detent position.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   cmd (slave)        : command handshake (dir, steps)
//   abort              : finish the current detent, then stop
//   pos_clear          : zero the position counter (wins over a detent step)
//   rotary_a/rotary_b  : quadrature outputs, straight from flops
//   busy/done/aborted  : command status; aborted qualifies done
//   pos_count          : signed detent position, two's-complement wrap
// Revision    : 1.0 - initial release
// ============================================================================
module quad_encoder_tx
    import quad_encoder_pkg::*;
#(
    parameter int PHASE_CYCLES = 1000,
    parameter int STEPS_W      = 8,
    parameter int POS_W        = 16
) (
    input  wire logic           wb_clk_i,
    input  wire logic           wb_rst_i,
    quad_encoder_tx_if.slave    cmd,
    input  wire logic           abort,
    input  wire logic           pos_clear,
    output logic                rotary_a,
    output logic                rotary_b,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [POS_W-1:0]    pos_count
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_ab;
    logic [1:0]         r_phase;
    logic [1:0]         w_phase_nxt;
    logic               r_dir;
    logic               r_abort;
    logic               r_aborted;
    logic [STEPS_W-1:0] r_remaining;
    logic [POS_W-1:0]   r_pos;
    logic               w_accept;
    logic               w_in_phase;
    logic               w_tick;
    logic               w_detent_end;
    logic               w_abort_any;
    logic               w_last;

    assign w_accept     = cmd.cmd_valid && (r_state == IDLE);
    assign w_in_phase   = (r_state == PHASE);
    assign w_phase_nxt  = r_phase + 2'd1;
    // Phase index 3 -> 0 is the step back to rest, i.e. a finished detent.
    assign w_detent_end = w_tick && (r_phase == 2'd3);
    // Abort raised on the boundary edge itself still stops at that boundary.
    assign w_abort_any  = r_abort || abort;
    assign w_last       = (r_remaining == STEPS_W'(1));

    quad_phase_timer #(
        .PHASE_CYCLES (PHASE_CYCLES)
    ) u_timer (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .i_clear (w_accept),
        .i_en    (w_in_phase),
        .o_tick  (w_tick)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (cmd.cmd_steps == '0) ? DONE : PHASE;
                end
            end
            PHASE: begin
                if (w_detent_end && (w_last || w_abort_any)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Waveform, step count and abort bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ab        <= REST_AB;
            r_phase     <= 2'd0;
            r_dir       <= 1'b0;
            r_remaining <= '0;
            r_abort     <= 1'b0;
            r_aborted   <= 1'b0;
        end else if (w_accept) begin
            r_dir       <= cmd.cmd_dir;
            r_remaining <= cmd.cmd_steps;
            r_phase     <= 2'd0;
            r_abort     <= 1'b0;
            r_aborted   <= 1'b0;
        end else if (w_in_phase) begin
            if (abort) begin
                r_abort <= 1'b1;
            end
            if (w_tick) begin
                r_phase <= w_phase_nxt;
                r_ab    <= gray_ab(r_dir, w_phase_nxt);
            end
            if (w_detent_end) begin
                r_remaining <= r_remaining - STEPS_W'(1);
                // Only an early stop counts as aborted.
                r_aborted   <= w_abort_any && !w_last;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || pos_clear) begin
            r_pos <= '0;
        end else if (w_detent_end) begin
            r_pos <= r_dir ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
        end
    end

    assign cmd.cmd_ready = (r_state == IDLE);
    assign busy          = (r_state != IDLE);
    assign done          = (r_state == DONE);
    assign aborted       = done && r_aborted;
    assign rotary_a      = r_ab[1];
    assign rotary_b      = r_ab[0];
    assign pos_count     = r_pos;

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_quad_encoder_tx
// Description : Self-checking bench for quad_encoder_tx with PHASE_CYCLES=4.
//               Commands come from a vector table and from random draws;
//               every cycle of each command is compared with a time-based
//               reference model, and a monitor checks each A/B transition
//               is a single-bit Gray step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_encoder_tx;

    localparam int PC  = 4;
    localparam int DET = 4 * PC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        abort = 1'b0;
    logic        pos_clear = 1'b0;
    logic        a, b, busy, done, aborted;
    logic [15:0] pos;

    quad_encoder_tx_if #(.STEPS_W(8)) cmd_if ();

    quad_encoder_tx #(
        .PHASE_CYCLES (PC),
        .STEPS_W      (8),
        .POS_W        (16)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cmd       (cmd_if),
        .abort     (abort),
        .pos_clear (pos_clear),
        .rotary_a  (a),
        .rotary_b  (b),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .pos_count (pos)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] m_pos;
    logic [1:0]  cw_seq  [4];
    logic [1:0]  ccw_seq [4];

    typedef struct {
        bit          dir;
        int          steps;
        int          ab_at;   // edge (relative to accept) where abort is seen, -1 = none
        int          clr_at;  // edge where pos_clear is seen, -1 = none
        bit          hold;    // keep cmd_valid high while busy
        logic [15:0] exp_pos;
        bit          exp_abt;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Gray monitor: every A/B change not caused by reset flips exactly one bit.
    logic [1:0] mon_prev = 2'b11;
    logic       mon_rst;
    always @(posedge clk) begin
        mon_rst = rst;
        #2;
        if (!mon_rst && ({a, b} != mon_prev)) begin
            n_chk++;
            if ($countones({a, b} ^ mon_prev) != 1) begin
                n_err++;
                $display("FAIL gray_step: %b -> %b", mon_prev, {a, b});
            end
        end
        mon_prev = {a, b};
    end

    // Runs one command from the accept edge (k=0) to two cycles past its end.
    // Sample k is taken on the negedge after accept edge + k.
    task automatic run_cmd(input int id, input bit dir, input int steps, input int ab_at,
                           input int clr_at, input bit hold, output bit abt_seen);
        int          d, e, n;
        logic [1:0]  eab;
        logic [21:0] got, exp;
        if (steps == 0) d = 0;
        else if (ab_at >= 1) begin
            d = (ab_at + DET - 1) / DET;
            if (d > steps) d = steps;
        end else d = steps;
        e = DET * d;
        abt_seen = 1'b0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir   = dir;
        cmd_if.cmd_steps = 8'(steps);
        abort     = 1'b0;
        pos_clear = (clr_at == 0);
        for (int k = 0; k <= e + 2; k++) begin
            @(negedge clk);
            if (clr_at == k) m_pos = 16'h0000;
            else if (k > 0 && (k % DET) == 0 && (k / DET) <= d)
                m_pos = dir ? m_pos + 16'd1 : m_pos - 16'd1;
            n = k / PC;
            if (n > 4 * d) n = 4 * d;
            eab = dir ? cw_seq[n % 4] : ccw_seq[n % 4];
            exp = {eab, (k > e), (k <= e), (k == e), ((k == e) && (d < steps)), m_pos};
            got = {a, b, cmd_if.cmd_ready, busy, done, aborted, pos};
            if (k == e) abt_seen = aborted;
            check($sformatf("cyc cmd%0d k=%0d {ab,rdy,busy,done,abt,pos}", id, k), 64'(got), 64'(exp));
            cmd_if.cmd_valid = hold && (k + 1 <= e + 1);
            if (hold) begin
                cmd_if.cmd_dir   = 1'($urandom_range(0, 1));
                cmd_if.cmd_steps = 8'($urandom_range(0, 255));
            end
            abort     = (ab_at == k + 1);
            pos_clear = (clr_at == k + 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit abt;
        cw_seq  = '{2'b11, 2'b01, 2'b00, 2'b10};
        ccw_seq = '{2'b11, 2'b10, 2'b00, 2'b01};
        //          dir steps ab_at clr_at hold exp_pos   exp_abt
        tbl[0] = '{1'b1,   2,   -1,   -1, 1'b0, 16'h0002, 1'b0};
        tbl[1] = '{1'b0,   3,   -1,   -1, 1'b0, 16'hFFFF, 1'b0};
        tbl[2] = '{1'b1,   0,   -1,   -1, 1'b0, 16'hFFFF, 1'b0};
        tbl[3] = '{1'b1,   5,    6,   -1, 1'b0, 16'h0000, 1'b1};
        tbl[4] = '{1'b1,   3,   -1,   -1, 1'b1, 16'h0003, 1'b0};
        tbl[5] = '{1'b0,   1,   -1,   16, 1'b0, 16'h0000, 1'b0};
        tbl[6] = '{1'b0, 255,   -1,   -1, 1'b0, 16'hFF01, 1'b0};
        tbl[7] = '{1'b1,   3,   16,   -1, 1'b0, 16'hFF02, 1'b1};

        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_steps = 8'd0;
        m_pos = 16'h0000;

        // Reset held for three cycles.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset {a,b}", 64'({a, b}), 64'(2'b11));
        check("reset {rdy,busy,done,abt}", 64'({cmd_if.cmd_ready, busy, done, aborted}), 64'(4'b1000));
        check("reset pos", 64'(pos), 64'(16'h0000));
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            run_cmd(i, tbl[i].dir, tbl[i].steps, tbl[i].ab_at, tbl[i].clr_at, tbl[i].hold, abt);
            check($sformatf("tbl%0d final pos", i), 64'(pos), 64'(tbl[i].exp_pos));
            check($sformatf("tbl%0d aborted at done", i), 64'(abt), 64'(tbl[i].exp_abt));
        end

        // Reset in the middle of a CW command: A/B jumps back to rest.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir   = 1'b1;
        cmd_if.cmd_steps = 8'd5;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("mid-cmd {a,b} before reset", 64'({a, b}), 64'(2'b00));
        check("mid-cmd busy before reset", 64'(busy), 64'(1'b1));
        rst = 1'b1;
        @(negedge clk);
        m_pos = 16'h0000;
        check("mid-cmd reset {a,b}", 64'({a, b}), 64'(2'b11));
        check("mid-cmd reset {rdy,busy,done}", 64'({cmd_if.cmd_ready, busy, done}), 64'(3'b100));
        check("mid-cmd reset pos", 64'(pos), 64'(m_pos));
        rst = 1'b0;

        // Random commands against the reference model.
        for (int r = 0; r < 24; r++) begin
            bit dir, hold;
            int steps, ab_at, clr_at;
            dir    = 1'($urandom_range(0, 1));
            steps  = $urandom_range(0, 3);
            ab_at  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 48) : -1;
            clr_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 50) : -1;
            hold   = 1'($urandom_range(0, 1));
            run_cmd(100 + r, dir, steps, ab_at, clr_at, hold, abt);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
